// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, with timeout and flush handling.
// Optional misaligned-PC trap is enabled with the macro IFU_MISALIGN_TRAP_EN.
module ifu_fetch #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ILEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            if_ram_valid_i,
  input  logic            flush_valid_i,
  output logic            fetch_busy_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            imem_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [1:0]      inst_exc_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID, S_DROP} state_e;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_ACCESS   = 2'd2;
  localparam logic [7:0] TO_LAST      = 8'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [1:0]      exc_q, exc_d;

  logic launch;
  logic misaligned;
  logic timeout;

  assign launch  = (state_q == S_IDLE) & if_ram_valid_i & ~flush_valid_i;
  assign timeout = (cnt_q == TO_LAST);

`ifdef IFU_MISALIGN_TRAP_EN
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;

    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          addr_d = {pc_i[XLEN-1:2], 2'b00};
          pc_d   = pc_i;
          cnt_d  = 8'd0;
          if (misaligned) begin
            state_d = S_VALID;
            valid_d = 1'b1;
            inst_d  = '0;
            exc_d   = EXC_MISALIGN;
          end else begin
            state_d = S_WAIT;
            req_d   = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (!imem_ack_i) cnt_d = cnt_q + 8'd1;
        if (flush_valid_i) begin
          // A response or timeout landing with the flush closes the request outright.
          if (imem_ack_i || timeout) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ack_i) begin
          state_d = S_VALID;
          req_d   = 1'b0;
          valid_d = 1'b1;
          inst_d  = imem_rdata_i;
          exc_d   = imem_err_i ? EXC_ACCESS : EXC_NONE;
        end else if (timeout) begin
          state_d = S_VALID;
          req_d   = 1'b0;
          valid_d = 1'b1;
          inst_d  = '0;
          exc_d   = EXC_ACCESS;
        end
      end

      S_DROP: begin
        if (!imem_ack_i) cnt_d = cnt_q + 8'd1;
        if (imem_ack_i || timeout) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end

      S_VALID: begin
        if (flush_valid_i || inst_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register, data included,
  // is reset so all outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

  // The stall is combinational, so it is gated by rst to read zero during reset.
  assign fetch_busy_o = ~rst & ((state_q != S_IDLE) | launch)
                        & ~((state_q == S_VALID) & inst_ready_i);

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = pc_q;
  assign inst_exc_o   = exc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_ifu_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        v, flush, ack, err, ready;
  logic [31:0] rdata;
  logic        busy, req, ivalid;
  logic [63:0] addr, ipc;
  logic [31:0] inst;
  logic [1:0]  exc;

  int n_checks = 0;
  int n_err    = 0;

  // Transaction-level model: is a request in flight, is it being discarded,
  // is an instruction held for decode, and how long the request has waited.
  bit          m_pending, m_drop, m_have;
  int          m_age;
  logic [63:0] m_addr, m_pc;
  logic [31:0] m_inst;
  logic [1:0]  m_exc;

  ifu_fetch #(.XLEN(64), .ILEN(32), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc),
    .if_ram_valid_i (v),
    .flush_valid_i  (flush),
    .fetch_busy_o   (busy),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_ack_i     (ack),
    .imem_rdata_i   (rdata),
    .imem_err_i     (err),
    .inst_valid_o   (ivalid),
    .inst_ready_i   (ready),
    .inst_o         (inst),
    .inst_pc_o      (ipc),
    .inst_exc_o     (exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model, mid-cycle, with this cycle's inputs applied.
  task automatic sample();
    bit e_launch, e_busy;
    @(negedge clk);
    if (rst) begin
      check("rst_req",   req,    0);
      check("rst_valid", ivalid, 0);
      check("rst_busy",  busy,   0);
      check("rst_inst",  inst,   0);
      check("rst_pc",    ipc,    0);
      check("rst_exc",   exc,    0);
      check("rst_addr",  addr,   0);
    end else begin
      e_launch = !m_pending && !m_have && v && !flush;
      e_busy   = (m_pending || m_have || e_launch) && !(m_have && ready);
      check("req",   req,    m_pending);
      check("valid", ivalid, m_have);
      check("busy",  busy,   e_busy);
      if (m_have) begin
        check("inst",    inst, m_inst);
        check("inst_pc", ipc,  m_pc);
        check("exc",     exc,  m_exc);
      end
      if (m_pending) check("addr", addr, m_addr);
    end
  endtask

  // Advance the model across the rising edge using the inputs held this cycle.
  task automatic advance();
    int  waited;
    bit  expired;
    @(posedge clk);
    if (rst) begin
      m_pending = 0; m_drop = 0; m_have = 0; m_age = 0;
    end else if (m_have) begin
      if (ready || flush) m_have = 0;
    end else if (m_pending) begin
      waited  = m_age + 1;
      expired = (waited >= TO);
      if (m_drop) begin
        if (ack || expired) m_pending = 0;
      end else if (flush) begin
        if (ack || expired) m_pending = 0;
        else m_drop = 1;
      end else if (ack) begin
        m_pending = 0; m_have = 1; m_inst = rdata; m_exc = err ? 2'd2 : 2'd0;
      end else if (expired) begin
        m_pending = 0; m_have = 1; m_inst = 0; m_exc = 2'd2;
      end
      m_age = waited;
    end else if (v && !flush) begin
      m_pc   = pc;
      m_addr = pc & ~64'h3;
      m_age  = 0;
`ifdef IFU_MISALIGN_TRAP_EN
      if (pc[1:0] != 2'b00) begin
        m_have = 1; m_inst = 0; m_exc = 2'd1;
      end else begin
        m_pending = 1; m_drop = 0;
      end
`else
      m_pending = 1; m_drop = 0;
`endif
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    v = 0; flush = 0; ack = 0; err = 0; ready = 0; rdata = 0;
  endtask

  // Return the DUT to IDLE from any state: ack everything, accept everything.
  task automatic drain();
    v = 0; flush = 0; ack = 1; ready = 1;
    repeat (TO + 3) tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1; pc = 0; idle_inputs();
    m_pending = 0; m_drop = 0; m_have = 0; m_age = 0;
    m_addr = 0; m_pc = 0; m_inst = 0; m_exc = 0;
    tick(); tick();
    check("reset_valid_lit", ivalid, 0);
    check("reset_req_lit",   req,    0);
    rst = 0;
    tick();

    // Basic fetch: ack on the third WAIT cycle, decode ready at once.
    v = 1; pc = 64'h8000_0000;
    sample(); check("b_busy_launch", busy, 1); advance();
    v = 0;
    sample(); check("b_req", req, 1); check("b_addr", addr, 64'h8000_0000); advance();
    tick();
    ack = 1; rdata = 32'h0000_0013;
    tick();
    ack = 0; ready = 1;
    sample();
    check("b_valid", ivalid, 1); check("b_inst", inst, 32'h13);
    check("b_pc", ipc, 64'h8000_0000); check("b_exc", exc, 0); check("b_busy_rdy", busy, 0);
    advance();
    ready = 0;
    sample(); check("b_valid_drop", ivalid, 0); advance();

    // Decode backpressure: result held four cycles, then released.
    v = 1; pc = 64'h8000_0004;
    tick();
    v = 0; ack = 1; rdata = 32'hCAFE_0001;
    tick();
    ack = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("h_valid", ivalid, 1); check("h_inst", inst, 32'hCAFE_0001); check("h_busy", busy, 1);
      advance();
    end
    ready = 1;
    sample(); check("h_busy_rel", busy, 0); advance();
    ready = 0;
    sample(); check("h_valid_rel", ivalid, 0); advance();

    // Flush one cycle after launch, ack two cycles later; next launch accepted.
    v = 1; pc = 64'h8000_0008;
    tick();
    v = 0; flush = 1;
    tick();
    flush = 0;
    sample(); check("f_req_drop", req, 1); check("f_valid0", ivalid, 0); advance();
    ack = 1;
    sample(); check("f_valid1", ivalid, 0); advance();
    ack = 0; v = 1; pc = 64'h8000_0100;
    sample(); check("f_req_low", req, 0); check("f_relaunch", busy, 1); advance();
    v = 0;
    sample(); check("f_req_new", req, 1); check("f_addr_new", addr, 64'h8000_0100); advance();
    drain();

    // Timeout after TO WAIT cycles, then an access error reported by imem.
    v = 1; pc = 64'h8000_0200;
    tick();
    v = 0;
    for (int i = 0; i < TO; i++) begin
      sample(); check("t_req", req, 1); check("t_valid", ivalid, 0); advance();
    end
    ready = 1;
    sample(); check("t_valid_to", ivalid, 1); check("t_exc", exc, 2); check("t_inst", inst, 0); advance();
    ready = 0;
    v = 1; pc = 64'h8000_0204;
    tick();
    v = 0; ack = 1; err = 1; rdata = 32'hDEAD_BEEF;
    tick();
    ack = 0; err = 0; ready = 1;
    sample(); check("e_valid", ivalid, 1); check("e_exc", exc, 2); advance();
    ready = 0;
    tick();

    // Misaligned PC.
    v = 1; pc = 64'h8000_0002;
    tick();
    v = 0;
`ifdef IFU_MISALIGN_TRAP_EN
    sample(); check("m_req", req, 0); check("m_valid", ivalid, 1);
    check("m_exc", exc, 1); check("m_inst", inst, 0); advance();
`else
    sample(); check("m_req", req, 1); check("m_addr", addr, 64'h8000_0000); advance();
`endif
    drain();

    // Reset pulsed mid-WAIT, then a stray ack.
    v = 1; pc = 64'h8000_0300;
    tick();
    v = 0;
    tick();
    rst = 1;
    #1;
    check("r_req", req, 0); check("r_busy", busy, 0); check("r_addr", addr, 0);
    check("r_pc", ipc, 0); check("r_inst", inst, 0); check("r_exc", exc, 0); check("r_valid", ivalid, 0);
    sample(); advance();
    rst = 0; ack = 1; rdata = 32'h1234_5678;
    sample(); check("r_ack_busy", busy, 0); advance();
    ack = 0;
    sample(); check("r_ack_valid", ivalid, 0); check("r_ack_req", req, 0); advance();

    // Randomized traffic, including stray acks, flushes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      v     = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      ack   = ($urandom_range(0, 2) == 0);
      err   = ($urandom_range(0, 7) == 0);
      ready = $urandom_range(0, 1) == 1;
      rdata = $urandom();
      pc    = {$urandom(), $urandom()};
      tick();
    end
    rst = 0; idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter XLEN, default 64, address/PC width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles to wait for an imem ack (range 1..255, 8-bit counter).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pc_i  input  XLEN  current PC from the PC register.
REQ-007 if_ram_valid_i  input  1  fetch permitted for pc_i this cycle.
REQ-008 flush_valid_i  input  1  pipeline flush; discard in-flight/held fetch.
REQ-009 fetch_busy_o  output  1  stall request to the PC register (hold PC).
REQ-010 imem_req_o  output  1  instruction memory request, held until ack.
REQ-011 imem_addr_o  output  XLEN  registered fetch address.
REQ-012 imem_ack_i  input  1  memory response strobe, one cycle.
REQ-013 imem_rdata_i  input  ILEN  instruction data, valid with ack.
REQ-014 imem_err_i  input  1  access error, valid with ack.
REQ-015 inst_valid_o  output  1  fetched instruction available to decode.
REQ-016 inst_ready_i  input  1  decode accepts instruction this cycle.
REQ-017 inst_o / inst_pc_o  output  ILEN / XLEN  instruction and its PC.
REQ-018 inst_exc_o  output  2  0 none, 1 misaligned fetch, 2 access fault.

Function
REQ-019 FSM states IDLE, WAIT, VALID, DROP; launch = IDLE & if_ram_valid_i & ~flush_valid_i.
REQ-020 On launch: latch pc_i into imem_addr_o and inst_pc_o, go WAIT; imem_req_o = 1 exactly while in WAIT or DROP.
REQ-021 WAIT & imem_ack_i: capture rdata into inst_o, inst_exc_o = imem_err_i ? 2 : 0, go VALID next cycle (ack-to-valid latency 1).
REQ-022 VALID: inst_valid_o = 1, outputs stable; inst_ready_i → IDLE next cycle.
REQ-023 fetch_busy_o = (state != IDLE | launch) & ~(state == VALID & inst_ready_i).
REQ-024 Timeout counter clears on entry to WAIT, increments each WAIT/DROP cycle without ack; at TIMEOUT_CYC in WAIT → VALID with inst_exc_o = 2, inst_o = 0; in DROP → IDLE.
REQ-025 Flush in WAIT → DROP; DROP waits for ack (or timeout), discards data, → IDLE; no inst_valid_o is produced.
REQ-026 Flush in VALID → IDLE next cycle, inst_valid_o low next cycle, regardless of inst_ready_i.
REQ-027 Flush in IDLE suppresses launch; flush in DROP has no further effect.
REQ-028 Ack received in IDLE or VALID is ignored.
REQ-029 At most one outstanding request; no new launch until back in IDLE.

Reset
REQ-030 rst asserted at any time: state IDLE, counter 0; imem_req_o, inst_valid_o, fetch_busy_o, inst_exc_o, inst_o, imem_addr_o, inst_pc_o all 0 (combinational outputs reach 0 while rst is high).
REQ-031 Reset mid-WAIT abandons the request; any ack arriving after reset release while IDLE is ignored.

Configuration
REQ-032 Macro IFU_MISALIGN_TRAP_EN defined: launch with pc_i[1:0] != 0 issues no imem request, goes directly to VALID next cycle with inst_exc_o = 1, inst_o = 0.
REQ-033 Macro undefined: pc_i[1:0] ignored, imem_addr_o[1:0] forced 0, inst_exc_o never 1.

Verification
REQ-034 pc_i=0x80000000, valid=1, ack after 3 cycles with rdata=0x00000013, ready=1 → inst_valid_o 1 cycle, inst_pc_o=0x80000000, inst_exc_o=0, busy low that cycle.
REQ-035 Fetch complete, inst_ready_i=0 for 4 cycles → inst_valid_o, inst_o and busy held for 4 cycles; release on ready.
REQ-036 Flush 1 cycle after launch, ack 2 cycles later → no inst_valid_o; imem_req_o drops after ack; next launch accepted the following cycle.
REQ-037 TIMEOUT_CYC=4, no ack → inst_valid_o after 4 WAIT cycles with inst_exc_o=2; imem_err_i=1 on ack → inst_exc_o=2.
REQ-038 With IFU_MISALIGN_TRAP_EN, pc_i=0x80000002 → no imem_req_o, inst_exc_o=1 next cycle; without the macro → imem_addr_o=0x80000000.
REQ-039 rst pulsed during WAIT, then ack → all outputs 0, ack ignored, state IDLE.
